// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline plus the MULT/DIV IDLE/BUSY/DONE scheduler.
// Enables/flushes and MD_Go are combinational from this cycle's requests; HI/LO strobe/busy decode registered state.
module pipeline_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        Stall,
  input  logic        BranchTaken_D,
  input  logic        HaltReq_D,
  input  logic        HiLoRead_D,
  input  logic        MulDivStart_E,
  input  logic        MulDivIsDiv_E,
  output logic        PC_EN,
  output logic        IFID_EN,
  output logic        IDEX_EN,
  output logic        IFID_FLUSH,
  output logic        IDEX_FLUSH,
  output logic        EXMEM_FLUSH,
  output logic        MD_Go,
  output logic        MD_HiLoWE,
  output logic        MD_Busy,
  output logic        Halted,
  output logic [31:0] StallCycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

  md_state_t        r_state;
  md_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_halted;
  logic [31:0]      r_stall_cnt;

  logic w_accept;
  logic w_ex_stall;
  logic w_id_stall;
  logic w_halt_set;

  assign w_accept   = RST_n && MulDivStart_E && (r_state != BUSY) && !r_halted;
  assign w_ex_stall = MulDivStart_E && (r_state == BUSY);
  assign w_id_stall = Stall || (HiLoRead_D && ((r_state == BUSY) || w_accept));
  assign w_halt_set = RST_n && !r_halted && !w_ex_stall && !w_id_stall && HaltReq_D;

  // Mult/div scheduler: exactly LAT cycles in BUSY, one DONE cycle for the HI/LO write.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = MulDivIsDiv_E ? DIV_LD : MUL_LD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // One stall/flush class per cycle, highest priority first.
  always_comb begin
    PC_EN       = 1'b1;
    IFID_EN     = 1'b1;
    IDEX_EN     = 1'b1;
    IFID_FLUSH  = 1'b0;
    IDEX_FLUSH  = 1'b0;
    EXMEM_FLUSH = 1'b0;
    if (!RST_n) begin
      PC_EN   = 1'b0;
      IFID_EN = 1'b0;
      IDEX_EN = 1'b0;
    end else if (r_halted) begin
      PC_EN      = 1'b0;
      IFID_EN    = 1'b0;
      IDEX_FLUSH = 1'b1;
    end else if (w_ex_stall) begin
      PC_EN       = 1'b0;
      IFID_EN     = 1'b0;
      IDEX_EN     = 1'b0;
      EXMEM_FLUSH = 1'b1;
    end else if (w_id_stall || HaltReq_D) begin
      PC_EN      = 1'b0;
      IFID_EN    = 1'b0;
      IDEX_FLUSH = 1'b1;
    end else if (BranchTaken_D) begin
      IFID_FLUSH = 1'b1;
    end
  end

  assign MD_Go     = w_accept;
  assign MD_HiLoWE = (r_state == DONE);
  assign MD_Busy   = (r_state == BUSY);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_halted    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_halt_set) begin
        r_halted <= 1'b1;
      end
      if (!PC_EN && !r_halted && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign Halted      = r_halted;
  assign StallCycles = r_stall_cnt;

endmodule
